// File: rtl/button_parser.sv
// button_parser: per-channel two-flop synchronizer, tick-sampled debouncer and press edge detector.
// Defining BUTTON_PARSER_RELEASE_EN adds the `released` port carrying one-cycle release pulses.
module button_parser #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62_500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef BUTTON_PARSER_RELEASE_EN
  ,
  output logic [WIDTH-1:0] released
`endif
);

  localparam int SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PCW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PCW-1:0] PULSE_FULL  = PCW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [SCW-1:0]   sample_cnt;
  logic             tick;
  logic [PCW-1:0]   count [WIDTH];
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= in;
      sync_q    <= sync_meta;
    end
  end

  // One free-running sample counter paces every channel, so presses that start
  // together saturate on the same tick.
  always_ff @(posedge clk) begin
    if (rst || sample_cnt == SAMPLE_LAST) sample_cnt <= '0;
    else                                  sample_cnt <= sample_cnt + 1'b1;
  end

  assign tick = (sample_cnt == SAMPLE_LAST);

  // A low synced level clears the counter immediately, so any glitch restarts the debounce.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst || !sync_q[i])                   count[i] <= '0;
      else if (tick && (count[i] < PULSE_FULL)) count[i] <= count[i] + 1'b1;
    end
  end

  always_comb begin
    debounced = '0;
    for (int i = 0; i < WIDTH; i++) debounced[i] = (count[i] == PULSE_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      out  <= '0;
    end else begin
      prev <= debounced;
      out  <= debounced & ~prev;
    end
  end

`ifdef BUTTON_PARSER_RELEASE_EN
  always_ff @(posedge clk) begin
    if (rst) released <= '0;
    else     released <= ~debounced & prev;
  end
`endif

endmodule

// File: tb/tb_button_parser.sv
// tb_button_parser: directed, self-checking bench for button_parser at SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
// Release-pulse checks are included when BUTTON_PARSER_RELEASE_EN is defined.
module tb_button_parser;

  logic       clk;
  logic       rst;
  logic [3:0] in_v;
  logic [3:0] out_v;
`ifdef BUTTON_PARSER_RELEASE_EN
  logic [3:0] rel_v;
`endif

  int checks = 0;
  int errors = 0;

  button_parser #(
    .WIDTH(4),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in_v),
    .out(out_v)
`ifdef BUTTON_PARSER_RELEASE_EN
    ,
    .released(rel_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    in_v = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int first_k;
    int rel_pulses;
    int rel_k;
    logic seen;
    logic other;
    logic [3:0] pulse_val;

    rst = 1'b1;
    applyStimulus(4'b0000);
    step();
    step();
    checkOutput("reset_out_low", {28'd0, out_v}, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("first_cycle_after_reset", {28'd0, out_v}, 32'd0);
    repeat (3) step();

    // Single channel press held 40 cycles
    applyStimulus(4'b0001);
    pulses = 0; first_k = -1; other = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (out_v[0]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (out_v[3:1] != 3'b000) other = 1'b1;
    end
    checkOutput("single_pulse_count", pulses, 1);
    checkOutput("single_pulse_window", (first_k >= 11 && first_k <= 15), 1);
    checkOutput("single_other_bits", other, 0);
    applyStimulus(4'b0000);
    repeat (10) step();

    // Bouncing input never stays high long enough to saturate
    other = 1'b0;
    for (int c = 0; c < 60; c++) begin
      applyStimulus({2'b00, (c % 4) != 3, 1'b0});
      step();
      if (out_v != 4'b0000) other = 1'b1;
    end
    checkOutput("bounce_no_pulse", other, 0);
    applyStimulus(4'b0000);
    repeat (10) step();

    // Two channels pressed together
    applyStimulus(4'b1010);
    pulses = 0; pulse_val = 4'b0000;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (out_v != 4'b0000) begin
        pulses++;
        pulse_val = out_v;
      end
    end
    checkOutput("dual_pulse_cycles", pulses, 1);
    checkOutput("dual_pulse_value", {28'd0, pulse_val}, 32'h0000000a);
    applyStimulus(4'b0000);
    repeat (10) step();

    // Reset right after a pulse while the button stays held
    applyStimulus(4'b0100);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (out_v[2]) seen = 1'b1;
    end
    checkOutput("held_first_pulse_seen", seen, 1);
    rst = 1'b1;
    step();
    checkOutput("midhold_reset_out_low", {28'd0, out_v}, 32'd0);
    rst = 1'b0;
    pulses = 0; first_k = -1; other = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (out_v[2]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if ({out_v[3], out_v[1:0]} != 3'b000) other = 1'b1;
    end
    checkOutput("rearm_pulse_count", pulses, 1);
    checkOutput("rearm_pulse_window", (first_k >= 11 && first_k <= 15), 1);
    checkOutput("rearm_other_bits", other, 0);
    applyStimulus(4'b0000);
    repeat (10) step();

    // Press, release, press again
    pulses = 0; rel_pulses = 0; rel_k = -1;
    applyStimulus(4'b0001);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (out_v[0]) pulses++;
    end
    applyStimulus(4'b0000);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (out_v[0]) pulses++;
`ifdef BUTTON_PARSER_RELEASE_EN
      if (rel_v[0]) begin
        rel_pulses++;
        if (rel_k < 0) rel_k = k;
      end
`endif
    end
    applyStimulus(4'b0001);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (out_v[0]) pulses++;
    end
    checkOutput("repress_pulse_count", pulses, 2);
`ifdef BUTTON_PARSER_RELEASE_EN
    checkOutput("release_pulse_count", rel_pulses, 1);
    checkOutput("release_pulse_window", (rel_k >= 2 && rel_k <= 5), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
